// File: rtl/wptr_full_ctl.sv
// Write-side pointer and flag control for an asynchronous FIFO: Gray/binary write
// pointer, full / almost-full / occupancy flags against the synchronized read pointer.
module wptr_full_ctl #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE+1)'(AFULL_LEVEL);

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic              wovf_q, wovf_d;

  logic              accept;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] occ;
  logic [ADDRSIZE:0] rptr_full_pat;

  always_comb begin
    accept         = winc & ~wfull_q;
    wbinnext       = wbin_q + {{ADDRSIZE{1'b0}}, accept};
    wgraynext      = bin2gray(wbinnext);
    rbin_s         = gray2bin(wq2_rptr);
    // Modular difference stays correct across pointer wrap.
    occ            = wbinnext - rbin_s;
    rptr_full_pat  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wbin_d         = wbinnext;
    wptr_d         = wgraynext;
    wfull_d        = (wgraynext == rptr_full_pat);
    walmost_full_d = (occ >= AFULL_THR);
    wlevel_d       = occ;
    // Set has priority over clear so an overflow is never lost.
    wovf_d         = (winc & wfull_q) | (wovf_q & ~wovf_clr);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= wlevel_d;
      wovf_q         <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctl.sv
// Bench for wptr_full_ctl: occupancy-based reference model checked every cycle,
// plus directed literal expectations for reset, fill, overflow, drain, wrap and netting.
module tb_wptr_full_ctl;

  localparam int AW = 4;
  localparam int PW = 1 << (AW + 1);
  localparam int DEPTH = 1 << AW;
  localparam int AFL = 12;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic          wovf_clr;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wovf;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  int m_wbin, m_level;
  bit m_full, m_af, m_ovf;

  wptr_full_ctl #(.ADDRSIZE(AW), .AFULL_LEVEL(AFL)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) % PW;
  endfunction

  // Inverse Gray by search: the binary value whose Gray code matches.
  function automatic int bin_of_gray(input int g);
    for (int k = 0; k < PW; k++) begin
      if (gray_of(k) == g) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy = writes accepted minus reads seen, modulo pointer range.
  always @(posedge wclk) begin
    int nxt, occ;
    bit acc, was_full;
    if (wrst) begin
      m_wbin = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      was_full = m_full;
      acc = winc && !was_full;
      nxt = (m_wbin + (acc ? 1 : 0)) % PW;
      occ = (nxt - bin_of_gray(int'(wq2_rptr)) + PW) % PW;
      m_level = occ;
      m_full = (occ == DEPTH);
      m_af = (occ >= AFL);
      if (winc && was_full) m_ovf = 1;
      else if (wovf_clr) m_ovf = 0;
      m_wbin = nxt;
    end
  end

  always @(negedge wclk) begin
    if (chk_en) begin
      check("waddr", int'(waddr), m_wbin % DEPTH);
      check("wptr", int'(wptr), gray_of(m_wbin));
      check("wfull", int'(wfull), int'(m_full));
      check("walmost_full", int'(walmost_full), int'(m_af));
      check("wlevel", int'(wlevel), m_level);
      check("wovf", int'(wovf), int'(m_ovf));
    end
  end

  task automatic step(input bit rst, input bit inc, input int rp, input bit clr);
    @(negedge wclk);
    wrst = rst; winc = inc; wq2_rptr = rp[AW:0]; wovf_clr = clr;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b1; wq2_rptr = '0; wovf_clr = 1'b0;
    @(posedge wclk);
    #1;
    chk_en = 1'b1;

    // Reset with winc asserted
    step(1, 1, 0, 0);
    check("rst_wptr", int'(wptr), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_flags", int'({wfull, walmost_full, wovf}), 0);
    check("rst_wlevel", int'(wlevel), 0);

    // Fill
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 0);
      if (i == 11) check("fill11_af", int'(walmost_full), 0);
      if (i == 12) begin
        check("fill12_af", int'(walmost_full), 1);
        check("fill12_lvl", int'(wlevel), 12);
      end
      if (i == 15) check("fill15_full", int'(wfull), 0);
    end
    check("fill_full", int'(wfull), 1);
    check("fill_wptr", int'(wptr), 5'b11000);
    check("fill_lvl", int'(wlevel), 16);

    // Overflow
    step(0, 1, 0, 0);
    check("ovf_wptr", int'(wptr), 5'b11000);
    check("ovf_set", int'(wovf), 1);
    step(0, 0, 0, 1);
    check("ovf_clr", int'(wovf), 0);
    step(0, 1, 0, 1);
    check("ovf_set_wins", int'(wovf), 1);
    check("ovf_wptr2", int'(wptr), 5'b11000);

    // Drain one entry
    step(0, 0, 5'b00001, 0);
    check("drain_full", int'(wfull), 0);
    check("drain_lvl", int'(wlevel), 15);
    check("drain_af", int'(walmost_full), 1);
    step(0, 1, 5'b00001, 0);
    check("refill_full", int'(wfull), 1);

    // Reset mid-fill with a nonzero read pointer
    step(1, 1, 5'b10101, 1);
    check("rst2_wptr", int'(wptr), 0);
    check("rst2_lvl", int'(wlevel), 0);
    check("rst2_flags", int'({wfull, walmost_full, wovf}), 0);

    // Advance to wbin=30 while the reader keeps pace
    for (int k = 0; k < 30; k++) step(0, 1, gray_of(k), 0);
    check("pre_wrap_waddr", int'(waddr), 14);
    check("pre_wrap_lvl", int'(wlevel), 1);

    // Wrap: four writes from wbin=30 against read pointer 30
    for (int k = 0; k < 4; k++) step(0, 1, 5'b10001, 0);
    check("wrap_waddr", int'(waddr), 2);
    check("wrap_wptr", int'(wptr), 5'b00011);
    check("wrap_lvl", int'(wlevel), 4);
    check("wrap_full", int'(wfull), 0);

    // Write and read in the same cycle net to zero
    step(0, 1, 5'b10001, 0);
    check("sim_pre_lvl", int'(wlevel), 5);
    check("sim_pre_waddr", int'(waddr), 3);
    step(0, 1, 5'b10000, 0);
    check("sim_lvl", int'(wlevel), 5);
    check("sim_waddr", int'(waddr), 4);

    step(0, 0, 5'b10000, 0);
    @(negedge wclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
